wb_openram_banked: RTL and testbench
====================================

Name: wb_openram_banked

Overview:
- Wishbone classic slave bridging the caravel user-area bus to NUM_BANKS OpenRAM single-port (RW) macros.
- Successor to the single-macro wrapper; generalised in bank count, macro depth and macro read latency.
- Adds a state machine that gives writes a 1-cycle ack and reads a latency-correct registered ack.
- Adds base-address window decode with wbs_err_o for misses, plus abort handling.

Parameters:
- BASE_ADDR, 32'h3000_0000, byte base of window; aligned to window size.
- ADDR_WIDTH, 9, word-address bits per macro.
- NUM_BANKS, 2, macro count; power of two, 1..8. BANK_BITS = clog2(NUM_BANKS), 0 when 1.
- READ_LATENCY, 1, clock edges from macro capture to valid dout; 1..4.

Ports:
- wb_clk_i  in  1  bus and macro clock
- wb_rst_ni  in  1  reset, asynchronous, active-low
- wbs_cyc_i  in  1  cycle
- wbs_stb_i  in  1  strobe
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte lanes
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  ack, registered
- wbs_err_o  out  1  error ack, registered
- wbs_dat_o  out  32  read data, registered
- ram_csb  out  NUM_BANKS  per-bank chip select, active-low
- ram_web  out  NUM_BANKS  per-bank write enable, active-low
- ram_wmask  out  4*NUM_BANKS  per-bank byte mask; bank b uses bits [4b+3:4b]
- ram_addr  out  ADDR_WIDTH  shared word address
- ram_din  out  32  shared write data
- ram_dout  in  32*NUM_BANKS  per-bank read data; bank b uses bits [32b+31:32b]

Behaviour:
- Reset (wb_rst_ni low, async): state=IDLE, wbs_ack_o=0, wbs_err_o=0, wbs_dat_o=0, latency counter=0, latched bank=0. ram_csb and ram_web all ones throughout reset.
- Decode:
  - word = wbs_adr_i[ADDR_WIDTH+1:2].
  - bank = wbs_adr_i[ADDR_WIDTH+BANK_BITS+1:ADDR_WIDTH+2].
  - WIN = NUM_BANKS*4*2^ADDR_WIDTH bytes.
  - hit = (wbs_adr_i & ~(WIN-1)) == BASE_ADDR.
  - Byte offset wbs_adr_i[1:0] is ignored.
- ram_addr = word and ram_din = wbs_dat_i, both combinational and always driven.
- req = cyc & stb. In IDLE only: ram_csb[bank] = ~(req & hit & ~(we & sel==0)). All other banks, and all banks in other states, are held high.
- ram_web[bank] = ~we while selected; otherwise 1.
- ram_wmask[bank] = sel; other banks 0.
- FSM, single outstanding transaction:
  - IDLE, req & ~hit -> RESP; err<=1 next edge. No macro access.
  - IDLE, req & hit & we -> RESP; ack<=1 next edge. The macro write is captured on the same edge. With sel==0 the ack is still returned but no macro write occurs.
  - IDLE, req & hit & ~we -> RD_WAIT; latch bank; counter<=READ_LATENCY-1.
  - RD_WAIT -> if counter==0: wbs_dat_o<=ram_dout[latched bank], ack<=1, -> RESP. Else counter-1.
  - RESP: ack/err high for exactly this one cycle, then cleared; -> IDLE unconditionally. No new access is issued while in RESP.
- Latency, counted in edges after the request edge E0:
  - write/err: ack/err high in the cycle after E0.
  - read: ack high after edge E0+READ_LATENCY.
- Abort: cyc low in RD_WAIT -> IDLE at next edge, no ack, wbs_dat_o unchanged.
- ack and err are never high together; wbs_dat_o changes only on a read ack.
- Back-to-back: a request held after RESP is treated as a new transaction in IDLE.
- Reset asserted mid-transaction: immediate return to reset values; the pending ack is lost.

Test Plan:
- NUM_BANKS=2, ADDR_WIDTH=9. Write 0xDEADBEEF to 0x3000_0804 (bank 1, word 1), sel=0xF -> ram_csb=2'b01, ram_web[1]=0, ram_wmask[7:4]=F; ack 1 cycle later.
- Read 0x3000_0804 with READ_LATENCY=1, then 3; bank-1 model returns 0xDEADBEEF -> ack on edge E0+1 / E0+3 respectively; wbs_dat_o=0xDEADBEEF; bank 0 never selected.
- Byte write sel=4'b0010, data 0x0000AB00, to a word preloaded with 0x11223344 -> readback 0x1122AB44. Write with sel=0 -> ack, ram_csb all ones.
- Access 0x3000_1000 (one past window) and 0x3100_0000 -> wbs_err_o pulse 1 cycle, wbs_ack_o=0, no csb activity.
- Read with READ_LATENCY=3, drop cyc after 1 wait cycle -> no ack or err; next read completes normally.
- Assert wb_rst_ni low asynchronously mid-RD_WAIT -> ack/err/dat_o=0 immediately; after release, state=IDLE and the next write acks in 1 cycle.

Source files
------------

// File: rtl/wb_openram_banked.sv
`default_nettype none
// ============================================================================
// wb_openram_banked : Wishbone classic slave over NUM_BANKS OpenRAM RW macros
// Revision 1.0 - initial banked release
// ============================================================================
module wb_openram_banked #(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int          ADDR_WIDTH   = 9,
  parameter int          NUM_BANKS    = 2,
  parameter int          READ_LATENCY = 1
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_ni,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_we_i,
  input  logic [3:0]                wbs_sel_i,
  input  logic [31:0]               wbs_adr_i,
  input  logic [31:0]               wbs_dat_i,
  output logic                      wbs_ack_o,
  output logic                      wbs_err_o,
  output logic [31:0]               wbs_dat_o,
  output logic [NUM_BANKS-1:0]      ram_csb,
  output logic [NUM_BANKS-1:0]      ram_web,
  output logic [4*NUM_BANKS-1:0]    ram_wmask,
  output logic [ADDR_WIDTH-1:0]     ram_addr,
  output logic [31:0]               ram_din,
  input  logic [32*NUM_BANKS-1:0]   ram_dout
);

  localparam int          c_bank_bits = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
  localparam int          c_bank_w    = (c_bank_bits > 0) ? c_bank_bits : 1;
  localparam logic [31:0] c_win       = 32'(NUM_BANKS) << (ADDR_WIDTH + 2);
  localparam logic [1:0]  c_cnt_init  = 2'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_t;

  state_t              r_state;
  logic [1:0]          r_cnt;
  logic [c_bank_w-1:0] r_bank;
  logic [c_bank_w-1:0] w_bank;
  logic                w_req;
  logic                w_hit;
  logic                w_access;
  logic [31:0]         w_rd_data;

  assign w_req     = wbs_cyc_i & wbs_stb_i;
  assign w_hit     = (wbs_adr_i & ~(c_win - 32'd1)) == BASE_ADDR;
  assign ram_addr  = wbs_adr_i[ADDR_WIDTH+1:2];
  assign ram_din   = wbs_dat_i;
  assign w_rd_data = ram_dout[32*int'(r_bank) +: 32];

  // Gated by reset so the macros see no select while the bridge is held in reset.
  assign w_access = wb_rst_ni & (r_state == IDLE) & w_req & w_hit &
                    ~(wbs_we_i & (wbs_sel_i == 4'd0));

  generate
    if (c_bank_bits > 0) begin : g_bank_decode
      assign w_bank = wbs_adr_i[ADDR_WIDTH+c_bank_bits+1:ADDR_WIDTH+2];
    end else begin : g_single_bank
      assign w_bank = '0;
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic w_bank_match;
      assign w_bank_match          = (w_bank == c_bank_w'(b));
      assign ram_csb[b]            = ~(w_access & w_bank_match);
      assign ram_web[b]            = ~(w_access & w_bank_match & wbs_we_i);
      assign ram_wmask[4*b +: 4]   = w_bank_match ? wbs_sel_i : 4'd0;
    end
  endgenerate

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state   <= IDLE;
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      wbs_dat_o <= '0;
      r_cnt     <= '0;
      r_bank    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            if (!w_hit) begin
              wbs_err_o <= 1'b1;
              r_state   <= RESP;
            end else if (wbs_we_i) begin
              wbs_ack_o <= 1'b1;
              r_state   <= RESP;
            end else begin
              r_bank  <= w_bank;
              r_cnt   <= c_cnt_init;
              r_state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          // Master abort wins over a read that would complete on this edge.
          if (!wbs_cyc_i) begin
            r_state <= IDLE;
          end else if (r_cnt == 2'd0) begin
            wbs_dat_o <= w_rd_data;
            wbs_ack_o <= 1'b1;
            r_state   <= RESP;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        RESP: begin
          wbs_ack_o <= 1'b0;
          wbs_err_o <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_openram_banked.sv
`default_nettype none
// ============================================================================
// tb_wb_openram_banked : two bridges (read latency 1 and 3) against a model
// Revision 1.0 - initial bench
// ============================================================================
module tb_wb_openram_banked;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          AW   = 9;
  localparam int          NB   = 2;
  localparam int          DEP  = 1 << AW;
  localparam logic [31:0] WIN  = 32'(NB * 4 * DEP);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc_cnt = 0;

  logic        cyc [2], stb [2], we [2];
  logic [3:0]  sel [2];
  logic [31:0] adr [2], dati [2];
  logic        ack [2], err [2];
  logic [31:0] dato [2];
  logic [1:0]  csb [2], web [2];
  logic [7:0]  wmask [2];
  logic [8:0]  addr [2];
  logic [31:0] din [2];
  logic [63:0] dout [2];

  generate
    for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int RL = (g == 0) ? 1 : 3;
      bit [31:0] mem  [NB][DEP];
      bit [31:0] pipe [NB][RL];

      wb_openram_banked #(
        .BASE_ADDR(BASE), .ADDR_WIDTH(AW), .NUM_BANKS(NB), .READ_LATENCY(RL)
      ) u_dut (
        .wb_clk_i (clk),     .wb_rst_ni(rst_n),
        .wbs_cyc_i(cyc[g]),  .wbs_stb_i(stb[g]),  .wbs_we_i(we[g]),
        .wbs_sel_i(sel[g]),  .wbs_adr_i(adr[g]),  .wbs_dat_i(dati[g]),
        .wbs_ack_o(ack[g]),  .wbs_err_o(err[g]),  .wbs_dat_o(dato[g]),
        .ram_csb  (csb[g]),  .ram_web  (web[g]),  .ram_wmask(wmask[g]),
        .ram_addr (addr[g]), .ram_din  (din[g]),  .ram_dout (dout[g])
      );

      // OpenRAM-like macro: data read on the capture edge emerges RL-1 edges later
      always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
          if (!csb[g][b] && !web[g][b])
            for (int k = 0; k < 4; k++)
              if (wmask[g][4*b+k]) mem[b][addr[g]][8*k +: 8] <= din[g][8*k +: 8];
          if (!csb[g][b] && web[g][b]) pipe[b][0] <= mem[b][addr[g]];
          for (int j = 1; j < RL; j++) pipe[b][j] <= pipe[b][j-1];
        end
      end
      assign dout[g] = {pipe[1][RL-1], pipe[0][RL-1]};
    end
  endgenerate

  // ---------------- reference model state ----------------
  bit [31:0]   ref_mem [2][NB][DEP];
  int          ack_at [2] = '{-1, -1};
  bit          ack_err [2], ack_rd [2];
  logic [31:0] ack_dat [2];
  int          iss_at [2] = '{-1, -1};
  bit          iss_acc [2], iss_we [2];
  int          iss_bank [2], iss_word [2];
  logic [3:0]  iss_sel [2];
  logic [31:0] iss_din [2];
  logic [31:0] exp_dat [2] = '{32'd0, 32'd0};

  function automatic int rl(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc_cnt, act, expv);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc_cnt++;
  end

  // Compare process: every cycle, both instances
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      bit          resp;
      logic [1:0]  e_csb, e_web;
      logic [7:0]  e_mask;
      resp = rst_n && (cyc_cnt == ack_at[i]);
      if (!rst_n) exp_dat[i] = 32'd0;
      else if (resp && ack_rd[i]) exp_dat[i] = ack_dat[i];
      chk($sformatf("ack%0d", i), ack[i], resp && !ack_err[i]);
      chk($sformatf("err%0d", i), err[i], resp && ack_err[i]);
      chk($sformatf("dat%0d", i), dato[i], exp_dat[i]);
      e_csb = 2'b11;
      e_web = 2'b11;
      if (rst_n && cyc_cnt == iss_at[i] && iss_acc[i]) begin
        e_csb[iss_bank[i]] = 1'b0;
        if (iss_we[i]) e_web[iss_bank[i]] = 1'b0;
      end
      chk($sformatf("csb%0d", i), csb[i], e_csb);
      chk($sformatf("web%0d", i), web[i], e_web);
      if (cyc_cnt == iss_at[i]) begin
        e_mask = 8'd0;
        e_mask[4*iss_bank[i] +: 4] = iss_sel[i];
        chk($sformatf("wmask%0d", i), wmask[i], e_mask);
        chk($sformatf("addr%0d", i), addr[i], iss_word[i]);
        chk($sformatf("din%0d", i), din[i], iss_din[i]);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input int i, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    bit          hit;
    logic [31:0] off;
    int          bank, word, e0;
    @(posedge clk); #1;
    cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = w; adr[i] = a; dati[i] = d; sel[i] = s;
    off  = a - BASE;
    hit  = off < WIN;
    word = int'(off >> 2) % DEP;
    bank = int'(off >> (AW + 2)) % NB;
    e0   = cyc_cnt + 1;
    iss_at[i] = cyc_cnt; iss_acc[i] = hit && !(w && s == 4'd0); iss_we[i] = w;
    iss_bank[i] = bank; iss_word[i] = word; iss_sel[i] = s; iss_din[i] = d;
    ack_rd[i] = 1'b0; ack_err[i] = 1'b0;
    if (!hit) begin
      ack_at[i] = e0; ack_err[i] = 1'b1;
    end else if (w) begin
      ack_at[i] = e0;
      for (int k = 0; k < 4; k++)
        if (s[k]) ref_mem[i][bank][word][8*k +: 8] = d[8*k +: 8];
    end else begin
      ack_at[i] = e0 + rl(i); ack_rd[i] = 1'b1; ack_dat[i] = ref_mem[i][bank][word];
    end
  endtask

  task automatic finish(input int i, input int abort_k, output int n,
                        output bit got_ack, output bit got_err);
    n = 0; got_ack = 1'b0; got_err = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (ack[i] || err[i]) begin
        got_ack = ack[i]; got_err = err[i];
        break;
      end
      if (n == abort_k) begin
        ack_at[i] = -1;
        break;
      end
      if (n >= 8) begin
        checks++; errors++;
        $display("FAIL timeout inst%0d: no response after %0d edges, expected one", i, n);
        ack_at[i] = -1;
        break;
      end
      n++;
    end
    cyc[i] = 1'b0; stb[i] = 1'b0;
  endtask

  task automatic xact(input int i, input bit w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input int abort_k, output int n, output bit ga, output bit ge);
    issue(i, w, a, d, s);
    finish(i, abort_k, n, ga, ge);
  endtask

  initial begin
    int n;
    bit ga, ge;
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit ga, ge;
    for (int i = 0; i < 2; i++) begin
      cyc[i] = 0; stb[i] = 0; we[i] = 0; sel[i] = 0; adr[i] = 0; dati[i] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_csb", csb[0], 2'b11);
    chk("rst_web", web[1], 2'b11);
    chk("rst_ack", {ack[0], err[0], ack[1], err[1]}, 4'b0000);
    #1 rst_n = 1'b1;

    // bank-1 write, literal strobe pattern
    issue(0, 1, 32'h3000_0804, 32'hDEAD_BEEF, 4'hF);
    #2;
    chk("wr_csb", csb[0], 2'b01);
    chk("wr_web", web[0], 2'b01);
    chk("wr_mask", wmask[0][7:4], 4'hF);
    chk("wr_addr", addr[0], 9'd1);
    finish(0, -1, n, ga, ge);
    chk("wr_lat", n, 0);
    chk("wr_ack", ga, 1);

    issue(0, 0, 32'h3000_0804, 32'd0, 4'hF);
    #2;
    chk("rd_csb", csb[0], 2'b01);
    finish(0, -1, n, ga, ge);
    chk("rd1_lat", n, 1);
    chk("rd1_dat", dato[0], 32'hDEAD_BEEF);

    xact(1, 1, 32'h3000_0804, 32'hDEAD_BEEF, 4'hF, -1, n, ga, ge);
    xact(1, 0, 32'h3000_0804, 32'd0, 4'hF, -1, n, ga, ge);
    chk("rd3_lat", n, 3);
    chk("rd3_dat", dato[1], 32'hDEAD_BEEF);

    // byte lanes
    xact(0, 1, 32'h3000_0010, 32'h1122_3344, 4'hF, -1, n, ga, ge);
    xact(0, 1, 32'h3000_0012, 32'h0000_AB00, 4'b0010, -1, n, ga, ge);
    xact(0, 0, 32'h3000_0010, 32'd0, 4'hF, -1, n, ga, ge);
    chk("byte_dat", dato[0], 32'h1122_AB44);
    issue(0, 1, 32'h3000_0010, 32'hFFFF_FFFF, 4'h0);
    #2;
    chk("sel0_csb", csb[0], 2'b11);
    finish(0, -1, n, ga, ge);
    chk("sel0_ack", {ga, n[3:0]}, 5'b1_0000);
    xact(0, 0, 32'h3000_0010, 32'd0, 4'hF, -1, n, ga, ge);
    chk("sel0_dat", dato[0], 32'h1122_AB44);

    // window misses
    xact(0, 1, 32'h3000_1000, 32'h5555_5555, 4'hF, -1, n, ga, ge);
    chk("miss1", {ga, ge, n[3:0]}, 6'b01_0000);
    xact(0, 0, 32'h3100_0000, 32'd0, 4'hF, -1, n, ga, ge);
    chk("miss2", {ga, ge, n[3:0]}, 6'b01_0000);

    // abort after one wait cycle, then a normal read
    xact(1, 1, 32'h3000_0004, 32'hCAFE_F00D, 4'hF, -1, n, ga, ge);
    xact(1, 0, 32'h3000_0004, 32'd0, 4'hF, 1, n, ga, ge);
    chk("abort_resp", {ga, ge}, 2'b00);
    repeat (4) @(posedge clk);
    #1 chk("abort_dat", dato[1], 32'hDEAD_BEEF);
    xact(1, 0, 32'h3000_0004, 32'd0, 4'hF, -1, n, ga, ge);
    chk("post_abort_lat", n, 3);
    chk("post_abort_dat", dato[1], 32'hCAFE_F00D);

    // asynchronous reset while a read is waiting
    issue(1, 0, 32'h3000_0804, 32'd0, 4'hF);
    @(posedge clk);
    #3 rst_n = 1'b0;
    ack_at[1] = -1;
    #1;
    chk("arst_resp", {ack[1], err[1]}, 2'b00);
    chk("arst_dat", dato[1], 32'd0);
    chk("arst_csb", csb[1], 2'b11);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    xact(1, 1, 32'h3000_0100, 32'h0BAD_F00D, 4'hF, -1, n, ga, ge);
    chk("arst_wr", {ga, n[3:0]}, 5'b1_0000);

    // randomized traffic
    for (int it = 0; it < 160; it++) begin
      int          i, k;
      bit          w;
      logic [31:0] a;
      i = int'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = BASE | ($urandom & 32'h0000_0FFC) | $urandom_range(0, 3);
      k = -1;
      if (!w && (a - BASE) < WIN && $urandom_range(0, 5) == 0)
        k = int'($urandom_range(0, rl(i) - 1));
      xact(i, w, a, $urandom, 4'($urandom), k, n, ga, ge);
    end

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
